mpc_pkt_rr_arb: RTL and testbench

Packet-level round-robin arbiter that sits directly upstream of the 16:1 read-data mux in the multi-port cache output path. It picks one requesting input-port buffer, holds that grant from SOP to EOP, and drives the mux's enable and select. It also issues one-hot read enables to the port buffers and recovers from a stalled source via a watchdog.

---
 rtl/mpc_pkt_rr_arb_if.sv | 31 +++
 rtl/mpc_pkt_rr_arb.sv | 105 ++++++++++
 tb/tb_mpc_pkt_rr_arb.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mpc_pkt_rr_arb_if.sv
// Handshake bundle between the packet round-robin arbiter and the port
// buffers / read-data mux it controls.
interface mpc_pkt_rr_arb_if #(
  parameter int unsigned IN_PORT_NUM = 16
) ();
  localparam int unsigned SEL_W = $clog2(IN_PORT_NUM);

  logic [IN_PORT_NUM-1:0] i_req;
  logic                   i_ready;
  logic                   i_rd_vld;
  logic                   i_rd_sop;
  logic                   i_rd_eop;
  logic                   o_en;
  logic [SEL_W-1:0]       o_sel;
  logic [IN_PORT_NUM-1:0] o_rd_en;
  logic                   o_busy;
  logic                   o_sop_err;
  logic                   o_timeout;

  // Arbiter side
  modport master (
    input  i_req, i_ready, i_rd_vld, i_rd_sop, i_rd_eop,
    output o_en, o_sel, o_rd_en, o_busy, o_sop_err, o_timeout
  );

  // Port-buffer / mux / downstream side
  modport slave (
    output i_req, i_ready, i_rd_vld, i_rd_sop, i_rd_eop,
    input  o_en, o_sel, o_rd_en, o_busy, o_sop_err, o_timeout
  );
endinterface

// File: rtl/mpc_pkt_rr_arb.sv
// Packet-level round-robin arbiter: holds a grant from SOP to EOP, drives the
// 16:1 read-data mux, checks SOP framing and aborts stalled sources.
module mpc_pkt_rr_arb #(
  parameter int unsigned IN_PORT_NUM = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  mpc_pkt_rr_arb_if.master      bus
);
  localparam int unsigned SEL_W = $clog2(IN_PORT_NUM);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] ptr;
  logic [WD_W-1:0]  wd;
  logic             first;
  logic             sop_err_q;
  logic             timeout_q;

  logic             en;
  logic             xfer;
  logic             starve;
  logic             win_vld;
  logic [SEL_W-1:0] win;

  assign en     = (state == BUSY) & bus.i_ready;
  assign xfer   = en & bus.i_rd_vld;
  assign starve = en & ~bus.i_rd_vld;

  // Scan upward from ptr+1; offset IN_PORT_NUM lands on ptr itself last.
  always_comb begin
    int unsigned      idx;
    logic [SEL_W-1:0] idx_s;
    idx     = 0;
    idx_s   = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned k = 1; k <= IN_PORT_NUM; k++) begin
      idx   = (32'(ptr) + k) % IN_PORT_NUM;
      idx_s = SEL_W'(idx);
      if (!win_vld && bus.i_req[idx_s]) begin
        win_vld = 1'b1;
        win     = idx_s;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      ptr       <= SEL_W'(IN_PORT_NUM - 1);
      wd        <= '0;
      first     <= 1'b0;
      sop_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sop_err_q <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            sel   <= win;
            wd    <= '0;
            first <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            wd        <= '0;
            first     <= 1'b0;
            // SOP must appear exactly on the first beat of the grant
            sop_err_q <= first ^ bus.i_rd_sop;
            if (bus.i_rd_eop) begin
              state <= IDLE;
              ptr   <= sel;
            end
          end else if (starve) begin
            if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
              state     <= IDLE;
              ptr       <= sel;
              timeout_q <= 1'b1;
              wd        <= '0;
            end else begin
              wd <= wd + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_en      = en;
  assign bus.o_sel     = sel;
  assign bus.o_rd_en   = en ? (IN_PORT_NUM'(1) << sel) : '0;
  assign bus.o_busy    = (state == BUSY);
  assign bus.o_sop_err = sop_err_q;
  assign bus.o_timeout = timeout_q;
endmodule

// File: tb/tb_mpc_pkt_rr_arb.sv
// Scoreboard bench for mpc_pkt_rr_arb: stimulus queues expected grants and
// error pulses; a negedge monitor pops and compares them as they appear.
module tb_mpc_pkt_rr_arb;
  localparam int unsigned N  = 16;
  localparam int          K_GNT = 0;
  localparam int          K_ERR = 1;
  localparam int          K_TO  = 2;

  logic clk;
  logic rst_n;

  mpc_pkt_rr_arb_if #(.IN_PORT_NUM(N)) bus ();

  mpc_pkt_rr_arb #(.IN_PORT_NUM(N), .TIMEOUT_CYC(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int kind;
    int val;
    int gap;
    int beats;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  // Source model state
  int   beat     = 0;
  int   src_len  = 4;
  int   sop_beat = 0;
  bit   src_on   = 1'b1;
  bit   mon_en   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp_v, exp_v);
    end
  endtask

  function automatic void push(input int kind, input int val, input int gap, input int beats);
    exp_t e;
    e.kind  = kind;
    e.val   = val;
    e.gap   = gap;
    e.beats = beats;
    expq.push_back(e);
  endfunction

  task automatic take(input int kind, input string nm, output exp_t e);
    e.kind  = -1;
    e.val   = 0;
    e.gap   = 0;
    e.beats = 0;
    if (expq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got unexpected event kind %0d, expected no event", nm, kind);
    end else begin
      e = expq.pop_front();
      chk({nm, "_kind"}, kind, e.kind);
    end
  endtask

  // One clock: drive FWFT source from o_en, then advance the beat on transfer.
  task automatic step(input int n);
    bit xfer;
    bit last;
    for (int i = 0; i < n; i++) begin
      #1;
      if (bus.o_en && src_on) begin
        bus.i_rd_vld = 1'b1;
        bus.i_rd_sop = (beat == sop_beat);
        bus.i_rd_eop = (beat == src_len - 1);
      end else begin
        bus.i_rd_vld = 1'b0;
        bus.i_rd_sop = 1'b0;
        bus.i_rd_eop = 1'b0;
      end
      xfer = bus.o_en && bus.i_rd_vld;
      last = bus.i_rd_eop;
      @(posedge clk);
      if (!rst_n)    beat = 0;
      else if (xfer) beat = last ? 0 : beat + 1;
      #1;
    end
  endtask

  // Monitor
  int   cyc       = 0;
  int   last_gnt  = 0;
  int   cur_port  = 0;
  int   cur_beats = 0;
  int   beat_cnt  = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (mon_en) begin
      if (bus.o_busy && !prev_busy) begin
        take(K_GNT, "grant", e);
        chk("grant_port", 32'(bus.o_sel), e.val);
        if (e.gap != 0) chk("grant_gap", cyc - last_gnt, e.gap);
        last_gnt  = cyc;
        cur_port  = e.val;
        cur_beats = e.beats;
        beat_cnt  = 0;
      end
      if (bus.o_en) chk("rd_en_grant", 32'(bus.o_rd_en), 32'(1) << cur_port);
      else          chk("rd_en_off", 32'(bus.o_rd_en), 0);
      if (bus.o_en && bus.i_rd_vld) begin
        beat_cnt++;
        chk("beat_sel", 32'(bus.o_sel), cur_port);
      end
      if (!bus.o_busy && prev_busy) chk("pkt_beats", beat_cnt, cur_beats);
      if (bus.o_sop_err) take(K_ERR, "sop_err", e);
      if (bus.o_timeout) begin
        take(K_TO, "timeout", e);
        chk("timeout_busy", 32'(bus.o_busy), 0);
      end
      prev_busy = bus.o_busy;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},      32'(bus.o_en), 0);
    chk({tag, "_sel"},     32'(bus.o_sel), 0);
    chk({tag, "_rd_en"},   32'(bus.o_rd_en), 0);
    chk({tag, "_busy"},    32'(bus.o_busy), 0);
    chk({tag, "_sop_err"}, 32'(bus.o_sop_err), 0);
    chk({tag, "_timeout"}, 32'(bus.o_timeout), 0);
  endtask

  initial begin
    int bad;
    rst_n        = 1'b0;
    bus.i_req    = '0;
    bus.i_ready  = 1'b1;
    bus.i_rd_vld = 1'b0;
    bus.i_rd_sop = 1'b0;
    bus.i_rd_eop = 1'b0;
    step(3);
    chk_all_zero("rst");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step(2);

    // Single port, 4 beats, regrant after one bubble
    src_len = 4;
    push(K_GNT, 0, 0, 4);
    push(K_GNT, 0, 5, 4);
    bus.i_req = 16'h0001;
    step(6);
    bus.i_req = '0;
    step(8);

    // Round robin from reset: 0..15 then 0, 3 cycles per 2-beat packet
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    src_len = 2;
    push(K_GNT, 0, 0, 2);
    for (int p = 1; p < 16; p++) push(K_GNT, p, 3, 2);
    push(K_GNT, 0, 3, 2);
    bus.i_req = 16'hFFFF;
    step(49);
    bus.i_req = '0;
    step(6);

    // Backpressure: 2000 cycles of i_ready=0 mid-packet
    src_len = 4;
    push(K_GNT, 5, 0, 4);
    bus.i_req = 16'h0020;
    step(1);
    bus.i_req = '0;
    step(2);
    bus.i_ready = 1'b0;
    bad = 0;
    for (int c = 0; c < 2000; c++) begin
      step(1);
      if (bus.o_en || bus.o_rd_en != '0 || bus.o_timeout || !bus.o_busy) bad++;
    end
    chk("bp_stall_cycles", bad, 0);
    bus.i_ready = 1'b1;
    step(6);

    // Starved source on port 3: abort after 8 cycles, next grant to port 4
    src_on = 1'b0;
    push(K_GNT, 3, 0, 0);
    push(K_TO, 0, 0, 0);
    push(K_GNT, 4, 9, 2);
    bus.i_req = 16'h0008;
    step(1);
    bus.i_req = 16'h0018;
    step(9);
    src_on    = 1'b1;
    src_len   = 2;
    bus.i_req = '0;
    step(5);

    // Framing: SOP on beat 1 of 3 gives errors on beats 0 and 1
    src_len  = 3;
    sop_beat = 1;
    push(K_GNT, 7, 0, 3);
    push(K_ERR, 0, 0, 0);
    push(K_ERR, 0, 0, 0);
    bus.i_req = 16'h0080;
    step(1);
    bus.i_req = '0;
    step(5);

    // Single-beat packet is legal
    sop_beat = 0;
    src_len  = 1;
    push(K_GNT, 9, 0, 1);
    bus.i_req = 16'h0200;
    step(1);
    bus.i_req = '0;
    step(3);

    // Reset during beat 2 of 5, then port 0 wins over port 2
    src_len = 5;
    push(K_GNT, 2, 0, 3);
    push(K_GNT, 0, 0, 5);
    bus.i_req = 16'h0004;
    step(3);
    rst_n = 1'b0;
    step(1);
    chk_all_zero("midrst");
    rst_n     = 1'b1;
    bus.i_req = 16'h0005;
    step(1);
    bus.i_req = '0;
    step(8);

    chk("scoreboard_left", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
